ln_unit: RTL and testbench
==========================

// Module: ln_unit
// PURPOSE
//  Iterative natural-log approximator; the inverse companion of the exp stage in the attention datapath.
//  Accepts one unsigned Q2.6 value per transaction and returns ln(x) as a signed Q3.6 result.
//  Sits after softmax-sum accumulation (log-sum-exp path); valid/ready on both sides.
//  Computes ln(x) = k*ln2 + ln(1+f):
//   - k, f come from sequential normalisation of x into m in [1,2).
//   - ln(1+f) is approximated by f - C2*f^2 with C2 = 20/64.
// PARAMETERS
//  IN_W   8   input width, unsigned Q2.6 (0 .. 3.984)
//  OUT_W  10  output width, signed Q3.6 (-8.0 .. 7.984)
//  FRAC   6   fraction bits, input and output
//  LN2_Q  44  ln2 in Q.6 LSBs (44/64)
//  C2_Q   20  quadratic coefficient numerator (20/64 ~= 0.3069 fit)
// PORTS
//  clk        in   1      clock, rising edge
//  rst        in   1      synchronous reset, active-high
//  in_valid   in   1      operand valid
//  in_ready   out  1      high only in IDLE
//  in_data    in   IN_W   unsigned Q2.6 operand
//  out_valid  out  1      result valid
//  out_ready  in   1      consumer accepts result
//  out_data   out  OUT_W  signed Q3.6 ln(in_data)
//  out_zero   out  1      input was 0; out_data is saturated to the minimum
// BEHAVIOUR
//  Reset values:
//   - state=IDLE; in_ready=1 after reset deasserts.
//   - out_valid=0, out_data=0, out_zero=0; internal m/k/p cleared.
//  Reset mid-operation aborts the transaction: no output, no partial result.
//  FSM: IDLE -> NORM -> SQ -> ACC -> DONE -> IDLE. One transaction in flight; no overlap.
//  IDLE: in_valid&in_ready -> m<=in_data, k<=0, out_zero<=0, go NORM.
//  NORM, one action per cycle, priority order:
//   - m==0: out_data<=-2^(OUT_W-1) (10'h200), out_zero<=1, go DONE.
//   - m[7]: m<=m>>1 (LSB truncated), k<=+1, stay.
//   - !m[6]: m<=m<<1, k<=k-1, stay.
//   - else (m in 64..127): go SQ.
//  k range is -6..+1; held as a 4-bit signed value.
//  SQ: F=m-64 (0..63); p<=F*F (12-bit unsigned).
//  ACC: q=(p*C2_Q + 2048)>>12 (round-half-up, 0..19).
//   - out_data <= k*LN2_Q + F - q, sign-extended to OUT_W; go DONE.
//   - Result range -264 .. +88; no saturation needed except for the zero case.
//   - C2 multiply is a shift-add (16+4); k*44 is a shift-add (32+8+4).
//  DONE: out_valid=1. out_data/out_zero stable while out_valid & !out_ready.
//   - out_ready -> IDLE; out_valid drops next cycle.
//  Latency (accept edge to out_valid high) = 3 + s, where s = number of NORM shifts (0..6).
//   - x=0: latency 1. Max latency 9 (x=1).
//  in_ready deasserts on the cycle after accept.
//   - Next accept no earlier than the cycle after the output handshake.
//  in_data is sampled only at accept; later changes are ignored.
//  out_valid never asserts without a preceding accept.
// STRUCTURE
//  Shared package ln_pkg:
//   - localparams LN2_Q, C2_Q, FRAC.
//   - enum ln_state_t {IDLE, NORM, SQ, ACC, DONE}.
//  Sub-module ln_poly: combinational (F, p, k) -> out_data for the ACC stage.
//   - Pure arithmetic; separately unit-testable.
//  Top ln_unit: FSM, normaliser registers, handshake.
// TESTING
//  x=64 (1.0) -> out_data=0, out_zero=0, latency 3.
//  x=128 (2.0) -> out_data=44 (0.6875), latency 4; x=255 -> 88, latency 4.
//  x=1 (1/64) -> out_data=-264 (10'h2F8), latency 9; x=32 (0.5) -> -44, latency 4.
//  x=96 (1.5) -> 27; x=127 -> 44; x=0 -> 10'h200 with out_zero=1, latency 1.
//  out_ready held low 10 cycles in DONE:
//   - out_data stable, in_ready=0, in_valid pulses ignored.
//   - Releasing out_ready -> IDLE next cycle.
//  rst pulsed during NORM for x=1 -> out_valid never rises, in_ready=1 after reset.
//   - Next x=64 -> 0 at latency 3.

Source files
------------

// File: rtl/ln_pkg.sv
// Shared constants and state encoding for the iterative natural-log unit.
package ln_pkg;

  localparam int IN_W  = 8;
  localparam int OUT_W = 10;
  localparam int FRAC  = 6;
  localparam int LN2_Q = 44;
  localparam int C2_Q  = 20;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    NORM = 3'd1,
    SQ   = 3'd2,
    ACC  = 3'd3,
    DONE = 3'd4
  } ln_state_t;

endpackage

// File: rtl/ln_poly.sv
// Combinational ACC-stage arithmetic: k*ln2 + F - round(C2*F^2), all in Q.6 LSBs.
module ln_poly
  import ln_pkg::*;
(
  input  logic [FRAC-1:0]  i_f,
  input  logic [11:0]      i_p,
  input  logic [3:0]       i_k,
  output logic [OUT_W-1:0] o_data
);

  logic [17:0]      w_pc2;
  logic [OUT_W-1:0] w_q;
  logic [OUT_W-1:0] w_k10;
  logic [OUT_W-1:0] w_kln2;

  // p*20 as p*16 + p*4, plus half an output LSB (2048 of 4096) for round-half-up
  assign w_pc2  = ({6'd0, i_p} << 4) + ({6'd0, i_p} << 2) + 18'd2048;
  assign w_q    = OUT_W'(w_pc2 >> 12);

  // k*44 as k*32 + k*8 + k*4; two's-complement wrap at OUT_W keeps the sign right
  assign w_k10  = {{(OUT_W-4){i_k[3]}}, i_k};
  assign w_kln2 = (w_k10 << 5) + (w_k10 << 3) + (w_k10 << 2);

  assign o_data = w_kln2 + {{(OUT_W-FRAC){1'b0}}, i_f} - w_q;

endmodule

// File: rtl/ln_unit.sv
// Iterative ln(x) for unsigned Q2.6 input, signed Q3.6 output, valid/ready on both sides.
module ln_unit
  import ln_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_zero
);

  ln_state_t        r_state;
  logic [IN_W-1:0]  r_m;
  logic [3:0]       r_k;
  logic [11:0]      r_p;
  logic             r_in_ready;
  logic             r_out_valid;
  logic [OUT_W-1:0] r_out_data;
  logic             r_out_zero;
  logic [11:0]      w_f12;
  logic [OUT_W-1:0] w_poly;

  // Once normalised, m is 64..127, so its low six bits are the fraction F
  assign w_f12 = {6'd0, r_m[FRAC-1:0]};

  ln_poly u_poly (
    .i_f    (r_m[FRAC-1:0]),
    .i_p    (r_p),
    .i_k    (r_k),
    .o_data (w_poly)
  );

  // Control FSM, normaliser datapath and registered handshake outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_m         <= 8'd0;
      r_k         <= 4'd0;
      r_p         <= 12'd0;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_out_data  <= 10'd0;
      r_out_zero  <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid && r_in_ready) begin
            r_m        <= in_data;
            r_k        <= 4'd0;
            r_out_zero <= 1'b0;
            r_in_ready <= 1'b0;
            r_state    <= NORM;
          end else begin
            r_in_ready <= 1'b1;
          end
        end
        NORM: begin
          if (r_m == 8'd0) begin
            r_out_data  <= 10'h200;
            r_out_zero  <= 1'b1;
            r_out_valid <= 1'b1;
            r_state     <= DONE;
          end else if (r_m[7]) begin
            r_m <= {1'b0, r_m[7:1]};
            r_k <= r_k + 4'd1;
          end else if (!r_m[6]) begin
            r_m <= {r_m[6:0], 1'b0};
            r_k <= r_k - 4'd1;
          end else begin
            r_state <= SQ;
          end
        end
        SQ: begin
          r_p     <= w_f12 * w_f12;
          r_state <= ACC;
        end
        ACC: begin
          r_out_data  <= w_poly;
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end else begin
            r_out_valid <= 1'b1;
          end
        end
        default: begin
          r_out_valid <= 1'b0;
          r_in_ready  <= 1'b1;
          r_state     <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_zero  = r_out_zero;

endmodule

// File: tb/tb_ln_unit.sv
// Scoreboard bench for ln_unit: directed corner values, stall, mid-run reset and random traffic.
module tb_ln_unit;

  logic       clk;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       out_valid;
  logic       out_ready;
  logic [9:0] out_data;
  logic       out_zero;

  typedef struct {
    int val;
    bit zero;
    int t;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_pass = 0;
  int   n_total = 0;
  bit   rand_bp = 0;
  bit   prev_v = 0;

  ln_unit dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_total++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: ln(x) = k*ln2 + F - round(0.3125*F^2) after scaling x into [1,2)
  function automatic exp_t model(input int x, input int now);
    exp_t e;
    int m, k, s, f, q;
    if (x == 0) begin
      e.val = -512; e.zero = 1'b1; e.t = now + 1 + 1;
    end else begin
      m = x; k = 0; s = 0;
      while (m >= 128) begin m = m / 2; k++; s++; end
      while (m < 64) begin m = m * 2; k--; s++; end
      f = m - 64;
      q = (f * f * 20 + 2048) / 4096;
      e.val = k * 44 + f - q;
      e.zero = 1'b0;
      e.t = now + 1 + 3 + s;
    end
    return e;
  endfunction

  // Monitor: latency on out_valid rise, data/zero on each output handshake
  always @(negedge clk) begin
    if (rst) begin
      prev_v = 1'b0;
    end else begin
      if (out_valid && !prev_v) begin
        if (sb.size() == 0) chk("spurious_valid", sb.size(), 1);
        else chk("latency", cyc, sb[0].t);
      end
      if (out_valid && out_ready && sb.size() != 0) begin
        exp_t e;
        e = sb.pop_front();
        chk("out_data", int'($signed(out_data)), e.val);
        chk("out_zero", int'(out_zero), int'(e.zero));
      end
      prev_v = out_valid;
    end
  end

  task automatic send(input logic [7:0] x);
    int n;
    n = 0;
    @(posedge clk); #1;
    while (!in_ready && n < 200) begin
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      n++;
    end
    if (!in_ready) begin
      chk("send_timeout", int'(in_ready), 1);
    end else begin
      if (rand_bp) out_ready = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      in_data  = x;
      sb.push_back(model(int'(x), cyc));
      @(posedge clk); #1;
      in_valid = 1'b0;
      in_data  = 8'($urandom);
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("drain", sb.size(), 0);
  endtask

  initial begin
    logic [7:0] dir[8];
    logic [9:0] held;
    int n;
    dir = '{8'd64, 8'd128, 8'd255, 8'd1, 8'd32, 8'd96, 8'd127, 8'd0};
    rst = 1'b1; in_valid = 1'b0; in_data = 8'd0; out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("rst_in_ready", int'(in_ready), 1);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_zero", int'(out_zero), 0);
    rst = 1'b0;

    foreach (dir[i]) send(dir[i]);
    drain();

    // Stall in DONE: output held, input side closed
    out_ready = 1'b0;
    send(8'd200);
    n = 0;
    while (!out_valid && n < 30) begin @(posedge clk); #1; n++; end
    chk("stall_reached", int'(out_valid), 1);
    held = out_data;
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_data  = 8'($urandom);
      @(posedge clk); #1;
      chk("stall_data", int'(out_data), int'(held));
      chk("stall_in_ready", int'(in_ready), 0);
      chk("stall_valid", int'(out_valid), 1);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("release_in_ready", int'(in_ready), 1);
    chk("release_valid", int'(out_valid), 0);

    // Reset during normalisation aborts the transaction
    send(8'd1);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_in_ready", int'(in_ready), 1);
    chk("abort_valid", int'(out_valid), 0);
    repeat (12) begin @(posedge clk); #1; end
    send(8'd64);
    drain();

    // Random traffic with random backpressure
    rand_bp = 1'b1;
    for (int i = 0; i < 200; i++) send(8'($urandom));
    rand_bp = 1'b0;
    drain();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
